passcode_serial_comparator: RTL and testbench

//  Source side of the passcode check. Latches an entered passcode and the stored user ID.

---
 rtl/passcode_pkg.sv | 13 +
 rtl/passcode_shift_reg.sv | 27 ++
 rtl/passcode_serial_comparator.sv | 136 +++++++++++++
 tb/tb_passcode_serial_comparator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/passcode_pkg.sv
// rtl/passcode_pkg.sv - FSM state encoding and PASS/FAIL codes shared with the decoder
package passcode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] PASS_CODE = 2'b01;
    localparam logic [1:0] FAIL_CODE = 2'b10;

endpackage

// File: rtl/passcode_shift_reg.sv
// rtl/passcode_shift_reg.sv - parallel-load, MSB-out left shifter
module passcode_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= {data_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/passcode_serial_comparator.sv
// rtl/passcode_serial_comparator.sv - serial MSB-first passcode/ID compare; lockout via PASSCODE_LOCKOUT_EN
module passcode_serial_comparator
    import passcode_pkg::*;
#(
    parameter int ID_WIDTH  = 16
`ifdef PASSCODE_LOCKOUT_EN
    ,
    parameter int MAX_FAILS = 3
`endif
) (
    input  logic                Clk_In,
    input  logic                Rst_In,
    input  logic                Start_In,
    input  logic [ID_WIDTH-1:0] Passcode_In,
    input  logic [ID_WIDTH-1:0] ID_Stored_In,
    output logic                Busy_Out,
    output logic                ID_MissMatch_Flag_Out,
    output logic                LastBitFlag_Out
`ifdef PASSCODE_LOCKOUT_EN
    ,
    output logic                Locked_Out
`endif
);

    localparam int CNT_W = $clog2(ID_WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             last_q, last_d;
    logic             load, shift;
    logic             code_msb, id_msb;
    logic             locked;

    passcode_shift_reg #(.WIDTH(ID_WIDTH)) u_code_sr (
        .clk_i   (Clk_In),
        .rst_i   (Rst_In),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (Passcode_In),
        .msb_o   (code_msb)
    );

    passcode_shift_reg #(.WIDTH(ID_WIDTH)) u_id_sr (
        .clk_i   (Clk_In),
        .rst_i   (Rst_In),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (ID_Stored_In),
        .msb_o   (id_msb)
    );

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        last_d  = last_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start_In && !locked) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(ID_WIDTH - 1);
                    mis_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                mis_d = mis_q | (code_msb ^ id_msb);
                // Leave SHIFT on bit 0 so the counter never wraps
                if (cnt_q == '0) begin
                    last_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PASSCODE_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic [FAIL_W-1:0] fail_q, fail_d;

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end

    // Fail count settles on the edge that enters DONE, using the final mismatch value
    always_comb begin
        fail_d = fail_q;
        if (state_q == SHIFT && cnt_q == '0) begin
            if (mis_d) begin
                if (fail_q != FAIL_W'(MAX_FAILS)) begin
                    fail_d = fail_q + 1'b1;
                end
            end else begin
                fail_d = '0;
            end
        end
    end

    assign locked     = (fail_q == FAIL_W'(MAX_FAILS));
    assign Locked_Out = locked;
`else
    assign locked = 1'b0;
`endif

    assign Busy_Out              = (state_q == SHIFT);
    assign ID_MissMatch_Flag_Out = mis_q;
    assign LastBitFlag_Out       = last_q;

endmodule

// File: tb/tb_passcode_serial_comparator.sv
// tb/tb_passcode_serial_comparator.sv - directed self-checking bench for passcode_serial_comparator
module tb_passcode_serial_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] code;
    logic [15:0] id;
    logic        busy;
    logic        mis;
    logic        last;
`ifdef PASSCODE_LOCKOUT_EN
    logic        locked;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    passcode_serial_comparator #(
        .ID_WIDTH (16)
`ifdef PASSCODE_LOCKOUT_EN
        ,
        .MAX_FAILS(3)
`endif
    ) dut (
        .Clk_In                (clk),
        .Rst_In                (rst),
        .Start_In              (start),
        .Passcode_In           (code),
        .ID_Stored_In          (id),
        .Busy_Out              (busy),
        .ID_MissMatch_Flag_Out (mis),
        .LastBitFlag_Out       (last)
`ifdef PASSCODE_LOCKOUT_EN
        ,
        .Locked_Out            (locked)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge 0, then edges 1..16; optional Start pulse (with a corrupted
    // code on the bus) at edge pulse_edge must be ignored.
    task automatic compare(input logic [15:0] c, input logic [15:0] i,
                           input int pulse_edge, input string tag);
        logic [15:0] diff;
        logic        exp_mis;
        diff  = c ^ i;
        code  = c;
        id    = i;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_e0_busy"}, 16'(busy), 16'd1);
        chk({tag, "_e0_last"}, 16'(last), 16'd0);
        chk({tag, "_e0_mis"},  16'(mis),  16'd0);
        for (int k = 1; k <= 16; k++) begin
            if (k == pulse_edge) begin
                start = 1'b1;
                code  = ~c;
            end
            tick();
            start   = 1'b0;
            code    = c;
            exp_mis = ((diff >> (16 - k)) != 16'd0);
            chk($sformatf("%s_e%0d_busy", tag, k), 16'(busy), 16'(k < 16));
            chk($sformatf("%s_e%0d_last", tag, k), 16'(last), 16'(k == 16));
            chk($sformatf("%s_e%0d_mis", tag, k),  16'(mis),  16'(exp_mis));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        code  = '0;
        id    = '0;
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_mis",  16'(mis),  16'd0);
        chk("rst_last", 16'(last), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_busy", 16'(busy), 16'd0);

        // 1: match
        compare(16'hA5C3, 16'hA5C3, 0, "match");
        tick();
        chk("match_hold_last", 16'(last), 16'd1);
        chk("match_hold_mis",  16'(mis),  16'd0);

        // 2: LSB-only miss; mismatch only appears with the last bit
        compare(16'hA5C2, 16'hA5C3, 0, "lsb");

        // 3: MSB miss; mismatch from edge 1 on
        compare(16'h25C3, 16'hA5C3, 0, "msb");
        tick();
        chk("msb_hold_mis",  16'(mis),  16'd1);
        chk("msb_hold_last", 16'(last), 16'd1);

        // 4: restart from DONE clears flags at edge 0; mid-compare Start ignored
        compare(16'hA5C3, 16'hA5C3, 5, "pulse_match");
        compare(16'h1234, 16'h1230, 5, "pulse_miss");

        // 5: async reset mid-compare
        code  = 16'h25C3;
        id    = 16'hA5C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("pre_rst_mis", 16'(mis), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_mis",  16'(mis),  16'd0);
        chk("arst_last", 16'(last), 16'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 16'(busy), 16'd0);
        compare(16'hBEEF, 16'hBEEF, 0, "post_rst");

`ifdef PASSCODE_LOCKOUT_EN
        // 6: three misses lock; a fourth Start is ignored
        chk("lock_init", 16'(locked), 16'd0);
        compare(16'h0001, 16'h0000, 0, "lk1");
        chk("lk1_locked", 16'(locked), 16'd0);
        compare(16'h0002, 16'h0000, 0, "lk2");
        chk("lk2_locked", 16'(locked), 16'd0);
        compare(16'h0004, 16'h0000, 0, "lk3");
        chk("lk3_locked", 16'(locked), 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lk4_busy", 16'(busy), 16'd0);
        chk("lk4_last", 16'(last), 16'd1);
        rst = 1'b1;
        #1;
        chk("lk_rst_clear", 16'(locked), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        compare(16'h8000, 16'h0000, 0, "ul1");
        compare(16'h4000, 16'h0000, 0, "ul2");
        compare(16'h7777, 16'h7777, 0, "ul3");
        chk("ul_locked", 16'(locked), 16'd0);
`else
        // 6: no lockout, five misses all complete
        for (int n = 0; n < 5; n++) begin
            compare(16'hFFFF, 16'(n), 0, $sformatf("nolock%0d", n));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
